// File: rtl/realtank_soc_bus_out_stage2_if.sv
// Bus bundle between the two input-port decoders, the output stage and the MI slave port.
interface realtank_soc_bus_out_stage2_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Decoder port 0
  logic          sel_op0;
  logic [AW-1:0] addr_op0;
  logic [1:0]    trans_op0;
  logic          write_op0;
  logic [2:0]    size_op0;
  logic [2:0]    burst_op0;
  logic [3:0]    prot_op0;
  logic          mastlock_op0;
  logic [DW-1:0] wdata_op0;
  logic          active_op0;
  logic          readyout_op0;
  logic [1:0]    resp_op0;

  // Decoder port 1
  logic          sel_op1;
  logic [AW-1:0] addr_op1;
  logic [1:0]    trans_op1;
  logic          write_op1;
  logic [2:0]    size_op1;
  logic [2:0]    burst_op1;
  logic [3:0]    prot_op1;
  logic          mastlock_op1;
  logic [DW-1:0] wdata_op1;
  logic          active_op1;
  logic          readyout_op1;
  logic [1:0]    resp_op1;

  // MI slave port
  logic          HSELM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [3:0]    HPROTM;
  logic          HMASTLOCKM;
  logic [DW-1:0] HWDATAM;
  logic          HREADYMUXM;
  logic          HREADYOUTM;
  logic [1:0]    HRESPM;

  // Output stage view: masters the MI bus, serves both decoders
  modport master (
    input  sel_op0, addr_op0, trans_op0, write_op0, size_op0, burst_op0,
           prot_op0, mastlock_op0, wdata_op0,
    input  sel_op1, addr_op1, trans_op1, write_op1, size_op1, burst_op1,
           prot_op1, mastlock_op1, wdata_op1,
    input  HREADYOUTM, HRESPM,
    output active_op0, readyout_op0, resp_op0,
    output active_op1, readyout_op1, resp_op1,
    output HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
           HMASTLOCKM, HWDATAM, HREADYMUXM
  );

  // Environment view: decoders plus the slave
  modport slave (
    output sel_op0, addr_op0, trans_op0, write_op0, size_op0, burst_op0,
           prot_op0, mastlock_op0, wdata_op0,
    output sel_op1, addr_op1, trans_op1, write_op1, size_op1, burst_op1,
           prot_op1, mastlock_op1, wdata_op1,
    output HREADYOUTM, HRESPM,
    input  active_op0, readyout_op0, resp_op0,
    input  active_op1, readyout_op1, resp_op1,
    input  HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
           HMASTLOCKM, HWDATAM, HREADYMUXM
  );
endinterface

// File: rtl/realtank_soc_bus_out_stage2.sv
// AHB-Lite output stage: arbitrates two decoder ports onto one MI slave port,
// keeping bursts and locked sequences on the same port.
module realtank_soc_bus_out_stage2 #(
  parameter int unsigned ARB_MODE = 1
) (
  input logic                          HCLK,
  input logic                          HRESETn,
  realtank_soc_bus_out_stage2_if.master bus
);

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam logic [1:0]  TRANS_IDLE = 2'b00;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  // Per-port views of the decoder inputs, index = port number
  logic [1:0]         sel_v;
  logic [1:0]         lock_v;
  logic [1:0]         write_v;
  logic [1:0]         req_v;
  logic [1:0][1:0]    trans_v;
  logic [1:0][2:0]    size_v;
  logic [1:0][2:0]    burst_v;
  logic [1:0][3:0]    prot_v;
  logic [1:0][AW-1:0] addr_v;
  logic [1:0][DW-1:0] wdata_v;

  assign sel_v   = {bus.sel_op1,      bus.sel_op0};
  assign lock_v  = {bus.mastlock_op1, bus.mastlock_op0};
  assign write_v = {bus.write_op1,    bus.write_op0};
  assign trans_v = {bus.trans_op1,    bus.trans_op0};
  assign size_v  = {bus.size_op1,     bus.size_op0};
  assign burst_v = {bus.burst_op1,    bus.burst_op0};
  assign prot_v  = {bus.prot_op1,     bus.prot_op0};
  assign addr_v  = {bus.addr_op1,     bus.addr_op0};
  assign wdata_v = {bus.wdata_op1,    bus.wdata_op0};

  assign req_v[0] = sel_v[0] & (trans_v[0] != TRANS_IDLE);
  assign req_v[1] = sel_v[1] & (trans_v[1] != TRANS_IDLE);

  logic owner_q;
  logic lock_hold_q;
  logic data_valid_q;
  logic data_port_q;
  logic rr_last_q;

  logic hready_c;
  logic hold_c;
  logic contend_c;
  logic grant_c;
  logic addr_sel_c;

  assign hready_c       = bus.HREADYOUTM;
  assign bus.HREADYMUXM = hready_c;

  // BUSY and SEQ both have trans[0] set: the owner is mid-burst and keeps the bus
  assign hold_c    = lock_hold_q | (sel_v[owner_q] & trans_v[owner_q][0]);
  assign contend_c = req_v[0] & req_v[1];

  // Address-phase grant; parks on the current owner when nobody asks
  always_comb begin
    grant_c = owner_q;
    if (!hready_c || hold_c) begin
      grant_c = owner_q;
    end else if (contend_c) begin
      grant_c = (ARB_MODE != 0) ? ~rr_last_q : 1'b0;
    end else if (req_v[0]) begin
      grant_c = 1'b0;
    end else if (req_v[1]) begin
      grant_c = 1'b1;
    end
  end

  // Slave-side buses stay quiet while reset is asserted, even if decoders still drive
  assign addr_sel_c = HRESETn & sel_v[grant_c];

  assign bus.HSELM      = addr_sel_c;
  assign bus.HTRANSM    = addr_sel_c ? trans_v[grant_c] : TRANS_IDLE;
  assign bus.HADDRM     = addr_v[grant_c];
  assign bus.HWRITEM    = write_v[grant_c];
  assign bus.HSIZEM     = size_v[grant_c];
  assign bus.HBURSTM    = burst_v[grant_c];
  assign bus.HPROTM     = prot_v[grant_c];
  assign bus.HMASTLOCKM = addr_sel_c & lock_v[grant_c];

  assign bus.active_op0 = HRESETn & ~grant_c & sel_v[0];
  assign bus.active_op1 = HRESETn &  grant_c & sel_v[1];

  // Data phase: only the port that owns it sees the slave's ready/response
  assign bus.HWDATAM      = wdata_v[data_port_q];
  assign bus.readyout_op0 = (data_valid_q && !data_port_q) ? hready_c : 1'b1;
  assign bus.readyout_op1 = (data_valid_q &&  data_port_q) ? hready_c : 1'b1;
  assign bus.resp_op0     = (data_valid_q && !data_port_q) ? bus.HRESPM : RESP_OKAY;
  assign bus.resp_op1     = (data_valid_q &&  data_port_q) ? bus.HRESPM : RESP_OKAY;

  // Arbitration and data-phase state advance only when the slave accepts a phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q      <= 1'b0;
      lock_hold_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_port_q  <= 1'b0;
      rr_last_q    <= 1'b1;
    end else if (hready_c) begin
      owner_q      <= grant_c;
      lock_hold_q  <= sel_v[grant_c] & lock_v[grant_c];
      data_valid_q <= addr_sel_c & trans_v[grant_c][1];
      data_port_q  <= grant_c;
      if (contend_c && !hold_c) begin
        rr_last_q <= grant_c;
      end
    end
  end

endmodule

// File: tb/tb_realtank_soc_bus_out_stage2.sv
// Self-checking bench for the two-port AHB-Lite output stage: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_realtank_soc_bus_out_stage2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Stimulus owned by the bench
  logic        p_sel[2];
  logic [1:0]  p_trans[2];
  logic [31:0] p_addr[2];
  logic        p_write[2];
  logic [2:0]  p_size[2];
  logic [2:0]  p_burst[2];
  logic [3:0]  p_prot[2];
  logic        p_lock[2];
  logic [31:0] p_wdata[2];
  logic        s_ready;
  logic [1:0]  s_resp;

  realtank_soc_bus_out_stage2_if bus_rr ();
  realtank_soc_bus_out_stage2_if bus_fp ();

  assign bus_rr.sel_op0 = p_sel[0];     assign bus_fp.sel_op0 = p_sel[0];
  assign bus_rr.addr_op0 = p_addr[0];   assign bus_fp.addr_op0 = p_addr[0];
  assign bus_rr.trans_op0 = p_trans[0]; assign bus_fp.trans_op0 = p_trans[0];
  assign bus_rr.write_op0 = p_write[0]; assign bus_fp.write_op0 = p_write[0];
  assign bus_rr.size_op0 = p_size[0];   assign bus_fp.size_op0 = p_size[0];
  assign bus_rr.burst_op0 = p_burst[0]; assign bus_fp.burst_op0 = p_burst[0];
  assign bus_rr.prot_op0 = p_prot[0];   assign bus_fp.prot_op0 = p_prot[0];
  assign bus_rr.mastlock_op0 = p_lock[0]; assign bus_fp.mastlock_op0 = p_lock[0];
  assign bus_rr.wdata_op0 = p_wdata[0]; assign bus_fp.wdata_op0 = p_wdata[0];
  assign bus_rr.sel_op1 = p_sel[1];     assign bus_fp.sel_op1 = p_sel[1];
  assign bus_rr.addr_op1 = p_addr[1];   assign bus_fp.addr_op1 = p_addr[1];
  assign bus_rr.trans_op1 = p_trans[1]; assign bus_fp.trans_op1 = p_trans[1];
  assign bus_rr.write_op1 = p_write[1]; assign bus_fp.write_op1 = p_write[1];
  assign bus_rr.size_op1 = p_size[1];   assign bus_fp.size_op1 = p_size[1];
  assign bus_rr.burst_op1 = p_burst[1]; assign bus_fp.burst_op1 = p_burst[1];
  assign bus_rr.prot_op1 = p_prot[1];   assign bus_fp.prot_op1 = p_prot[1];
  assign bus_rr.mastlock_op1 = p_lock[1]; assign bus_fp.mastlock_op1 = p_lock[1];
  assign bus_rr.wdata_op1 = p_wdata[1]; assign bus_fp.wdata_op1 = p_wdata[1];
  assign bus_rr.HREADYOUTM = s_ready;   assign bus_fp.HREADYOUTM = s_ready;
  assign bus_rr.HRESPM = s_resp;        assign bus_fp.HRESPM = s_resp;

  realtank_soc_bus_out_stage2 #(.ARB_MODE(1)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_rr)
  );
  realtank_soc_bus_out_stage2 #(.ARB_MODE(0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_fp)
  );

  // Reference model of the round-robin instance, in terms of bus ownership
  logic m_owner;     // port currently holding the address bus
  logic m_locked;    // a locked sequence is in progress
  logic m_dphase;    // a real transfer is in its data phase
  logic m_dport;     // port whose transfer is in data phase
  logic m_last_win;  // winner of the last contested arbitration

  function automatic logic wants(input int n);
    return p_sel[n] && (p_trans[n] != IDLE);
  endfunction

  function automatic logic mid_burst();
    int o = int'(m_owner);
    return m_locked || (p_sel[o] && (p_trans[o] == BUSY || p_trans[o] == SEQ));
  endfunction

  function automatic logic who_gets_bus();
    if (!s_ready || mid_burst()) return m_owner;
    if (wants(0) && wants(1))    return ~m_last_win;
    if (wants(0))                return 1'b0;
    if (wants(1))                return 1'b1;
    return m_owner;
  endfunction

  task automatic model_reset();
    m_owner = 1'b0; m_locked = 1'b0; m_dphase = 1'b0; m_dport = 1'b0; m_last_win = 1'b1;
  endtask

  // Advance one clock; the model takes the same decision the bus sees at the edge
  task automatic tick();
    logic g, contested;
    int   gi;
    g = who_gets_bus();
    gi = int'(g);
    contested = wants(0) && wants(1) && !mid_burst();
    @(posedge HCLK);
    if (HRESETn && s_ready) begin
      m_dphase = p_sel[gi] && (p_trans[gi] == NONSEQ || p_trans[gi] == SEQ);
      m_dport  = g;
      m_locked = p_sel[gi] && p_lock[gi];
      if (contested) m_last_win = g;
      m_owner  = g;
    end
    #1;
  endtask

  task automatic drive(input int n, input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic lk, input logic [31:0] wd, input logic [2:0] bu);
    p_sel[n] = sel; p_trans[n] = tr; p_addr[n] = a; p_write[n] = wr;
    p_lock[n] = lk; p_wdata[n] = wd; p_burst[n] = bu; p_size[n] = 3'd2; p_prot[n] = 4'h3;
  endtask

  task automatic quiet_inputs();
    for (int n = 0; n < 2; n++) drive(n, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 32'h0, SINGLE);
    s_ready = 1'b1; s_resp = 2'b00;
  endtask

  task automatic do_reset();
    quiet_inputs();
    HRESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge HCLK);
    checks++; if (bus_rr.HSELM !== 1'b0 || bus_rr.HTRANSM !== IDLE) begin
      errors++; $display("FAIL reset_bus got sel=%b trans=%b want sel=0 trans=00", bus_rr.HSELM, bus_rr.HTRANSM); end
    checks++; if ({bus_rr.active_op0, bus_rr.active_op1} !== 2'b00) begin
      errors++; $display("FAIL reset_active got %b%b want 00", bus_rr.active_op0, bus_rr.active_op1); end
    checks++; if ({bus_rr.readyout_op0, bus_rr.readyout_op1, bus_rr.resp_op0, bus_rr.resp_op1} !== 6'b11_0000) begin
      errors++; $display("FAIL reset_ready_resp got rdy=%b%b resp=%b/%b want rdy=11 resp=00/00",
                         bus_rr.readyout_op0, bus_rr.readyout_op1, bus_rr.resp_op0, bus_rr.resp_op1); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 1'b1, NONSEQ, 32'h0000_1000, 1'b0, 1'b0, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op1 !== 1'b1 || bus_rr.active_op0 !== 1'b0) begin
      errors++; $display("FAIL single_active got %b%b want op0=0 op1=1", bus_rr.active_op0, bus_rr.active_op1); end
    checks++; if (bus_rr.HADDRM !== 32'h0000_1000 || bus_rr.HTRANSM !== NONSEQ || bus_rr.HSELM !== 1'b1) begin
      errors++; $display("FAIL single_addr got %h/%b/%b want 00001000/10/1", bus_rr.HADDRM, bus_rr.HTRANSM, bus_rr.HSELM); end
    tick();
    drive(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 32'h0, SINGLE);
    s_ready = 1'b0; s_resp = 2'b00;
    @(negedge HCLK);
    checks++; if (bus_rr.readyout_op1 !== 1'b0 || bus_rr.readyout_op0 !== 1'b1) begin
      errors++; $display("FAIL single_wait got rdy0=%b rdy1=%b want 1/0", bus_rr.readyout_op0, bus_rr.readyout_op1); end
    s_ready = 1'b1;
    #1;
    checks++; if (bus_rr.readyout_op1 !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b want 1", bus_rr.readyout_op1); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, NONSEQ, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, SINGLE);
      drive(1, 1'b1, NONSEQ, 32'h200 + 32'(i), 1'b0, 1'b0, 32'h0, SINGLE);
      @(negedge HCLK);
      checks++; if (bus_rr.active_op0 !== 1'((i % 2) == 0) || bus_rr.active_op1 !== 1'((i % 2) == 1)) begin
        errors++; $display("FAIL rr_alternate cycle %0d got %b%b want op0=%0d", i, bus_rr.active_op0,
                           bus_rr.active_op1, int'((i % 2) == 0)); end
      checks++; if (bus_fp.active_op0 !== 1'b1 || bus_fp.active_op1 !== 1'b0 || bus_fp.HADDRM !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL fixed_prio cycle %0d got %b%b addr %h want 10 addr %h", i, bus_fp.active_op0,
                           bus_fp.active_op1, bus_fp.HADDRM, 32'h100 + 32'(i)); end
      tick();
    end
  endtask

  task automatic test_burst_hold();
    do_reset();
    drive(1, 1'b1, NONSEQ, 32'h0000_8000, 1'b0, 1'b0, 32'h0, SINGLE);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, (k == 0) ? NONSEQ : SEQ, 32'h100 + 32'(4 * k), 1'b0, 1'b0, 32'h0, INCR4);
      @(negedge HCLK);
      checks++; if (bus_rr.active_op0 !== 1'b1 || bus_rr.active_op1 !== 1'b0 || bus_rr.HADDRM !== 32'h100 + 32'(4 * k)) begin
        errors++; $display("FAIL burst_beat%0d got act=%b%b addr %h want 10 addr %h", k, bus_rr.active_op0,
                           bus_rr.active_op1, bus_rr.HADDRM, 32'h100 + 32'(4 * k)); end
      tick();
    end
    drive(0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op1 !== 1'b1 || bus_rr.HADDRM !== 32'h0000_8000) begin
      errors++; $display("FAIL burst_release got act1=%b addr %h want 1 addr 00008000", bus_rr.active_op1, bus_rr.HADDRM); end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    drive(1, 1'b1, NONSEQ, 32'h2000, 1'b0, 1'b1, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op1 !== 1'b1 || bus_rr.HMASTLOCKM !== 1'b1) begin
      errors++; $display("FAIL lock_start got act1=%b lock=%b want 1/1", bus_rr.active_op1, bus_rr.HMASTLOCKM); end
    tick();
    drive(0, 1'b1, NONSEQ, 32'h3000, 1'b0, 1'b0, 32'h0, SINGLE);
    drive(1, 1'b1, NONSEQ, 32'h2004, 1'b1, 1'b1, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op0 !== 1'b0 || bus_rr.HADDRM !== 32'h2004) begin
      errors++; $display("FAIL lock_block_wr got act0=%b addr %h want 0 addr 00002004", bus_rr.active_op0, bus_rr.HADDRM); end
    tick();
    drive(1, 1'b1, IDLE, 32'h2008, 1'b0, 1'b1, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op0 !== 1'b0) begin
      errors++; $display("FAIL lock_idle_keeps got act0=%b want 0", bus_rr.active_op0); end
    tick();
    drive(1, 1'b1, NONSEQ, 32'h2008, 1'b0, 1'b0, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op0 !== 1'b0 || bus_rr.active_op1 !== 1'b1) begin
      errors++; $display("FAIL lock_unlock_beat got act=%b%b want 01", bus_rr.active_op0, bus_rr.active_op1); end
    tick();
    drive(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 32'h0, SINGLE);
    @(negedge HCLK);
    checks++; if (bus_rr.active_op0 !== 1'b1 || bus_rr.HADDRM !== 32'h3000) begin
      errors++; $display("FAIL lock_release got act0=%b addr %h want 1 addr 00003000", bus_rr.active_op0, bus_rr.HADDRM); end
    tick();
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(0, 1'b1, NONSEQ, 32'h4000, 1'b1, 1'b0, 32'h0, SINGLE);
    tick();
    drive(0, 1'b1, NONSEQ, 32'h4004, 1'b1, 1'b0, 32'hCAFE_0001, SINGLE);
    drive(1, 1'b1, NONSEQ, 32'h5000, 1'b0, 1'b0, 32'h0, SINGLE);
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++; if (bus_rr.HADDRM !== 32'h4004 || bus_rr.HTRANSM !== NONSEQ || bus_rr.active_op1 !== 1'b0) begin
        errors++; $display("FAIL wait_addr%0d got %h/%b act1=%b want 00004004/10 act1=0", i, bus_rr.HADDRM,
                           bus_rr.HTRANSM, bus_rr.active_op1); end
      checks++; if (bus_rr.HWDATAM !== 32'hCAFE_0001 || bus_rr.readyout_op0 !== 1'b0) begin
        errors++; $display("FAIL wait_data%0d got %h rdy0=%b want cafe0001 rdy0=0", i, bus_rr.HWDATAM, bus_rr.readyout_op0); end
      tick();
    end
    s_ready = 1'b1;
    @(negedge HCLK);
    checks++; if (bus_rr.readyout_op0 !== 1'b1 || bus_rr.HWDATAM !== 32'hCAFE_0001) begin
      errors++; $display("FAIL wait_done got rdy0=%b data %h want 1 cafe0001", bus_rr.readyout_op0, bus_rr.HWDATAM); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, (k == 0) ? NONSEQ : SEQ, 32'h500 + 32'(4 * k), 1'b0, 1'b0, 32'h0, INCR8);
      tick();
    end
    drive(0, 1'b1, SEQ, 32'h50C, 1'b0, 1'b0, 32'h0, INCR8);
    drive(1, 1'b1, NONSEQ, 32'h700, 1'b0, 1'b0, 32'h0, SINGLE);
    s_ready = 1'b0; s_resp = 2'b01;
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_rr.HSELM !== 1'b0 || bus_rr.HTRANSM !== IDLE || {bus_rr.active_op0, bus_rr.active_op1} !== 2'b00) begin
      errors++; $display("FAIL rstmid_bus got sel=%b trans=%b act=%b%b want 0/00/00", bus_rr.HSELM, bus_rr.HTRANSM,
                         bus_rr.active_op0, bus_rr.active_op1); end
    checks++; if ({bus_rr.readyout_op0, bus_rr.readyout_op1, bus_rr.resp_op0} !== 4'b11_00) begin
      errors++; $display("FAIL rstmid_ready got rdy=%b%b resp0=%b want 11/00", bus_rr.readyout_op0,
                         bus_rr.readyout_op1, bus_rr.resp_op0); end
    @(posedge HCLK);
    #1;
    drive(0, 1'b1, NONSEQ, 32'h600, 1'b0, 1'b0, 32'h0, SINGLE);
    s_ready = 1'b1; s_resp = 2'b00;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    checks++; if (bus_rr.active_op0 !== 1'b1 || bus_rr.active_op1 !== 1'b0 || bus_rr.HADDRM !== 32'h600) begin
      errors++; $display("FAIL rstmid_rearb got act=%b%b addr %h want 10 addr 00000600", bus_rr.active_op0,
                         bus_rr.active_op1, bus_rr.HADDRM); end
    tick();
  endtask

  task automatic test_random();
    logic        g, en;
    int          gi, di;
    logic [46:0] exp_a, act_a;
    logic [39:0] exp_r, act_r;
    logic        rdy0, rdy1;
    logic [1:0]  rsp0, rsp1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        drive(n, ($urandom % 4) != 0, 2'($urandom), $urandom, 1'($urandom), ($urandom % 6) == 0,
              $urandom, 3'($urandom));
      end
      s_ready = ($urandom % 4) != 0;
      s_resp  = (($urandom % 5) == 0) ? 2'b01 : 2'b00;
      @(negedge HCLK);
      g  = who_gets_bus();
      gi = int'(g);
      di = int'(m_dport);
      en = p_sel[gi];
      exp_a = {en, en ? p_trans[gi] : IDLE, p_addr[gi], p_write[gi], p_size[gi], p_burst[gi],
               p_prot[gi], en && p_lock[gi]};
      act_a = {bus_rr.HSELM, bus_rr.HTRANSM, bus_rr.HADDRM, bus_rr.HWRITEM, bus_rr.HSIZEM,
               bus_rr.HBURSTM, bus_rr.HPROTM, bus_rr.HMASTLOCKM};
      rdy0 = (m_dphase && m_dport == 1'b0) ? s_ready : 1'b1;
      rdy1 = (m_dphase && m_dport == 1'b1) ? s_ready : 1'b1;
      rsp0 = (m_dphase && m_dport == 1'b0) ? s_resp : 2'b00;
      rsp1 = (m_dphase && m_dport == 1'b1) ? s_resp : 2'b00;
      exp_r = {(g == 1'b0) && p_sel[0], (g == 1'b1) && p_sel[1], rdy0, rdy1, rsp0, rsp1, p_wdata[di]};
      act_r = {bus_rr.active_op0, bus_rr.active_op1, bus_rr.readyout_op0, bus_rr.readyout_op1,
               bus_rr.resp_op0, bus_rr.resp_op1, bus_rr.HWDATAM};
      checks++; if (act_a !== exp_a) begin
        errors++; $display("FAIL rand_addr cycle %0d got %h want %h", c, act_a, exp_a); end
      checks++; if (act_r !== exp_r) begin
        errors++; $display("FAIL rand_return cycle %0d got %h want %h", c, act_r, exp_r); end
      tick();
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    quiet_inputs();
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_burst_hold();
    test_lock();
    test_wait_states();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
